gl_bram_arbiter: RTL

GL_BRAM_ARBITER -- requirements
Module: gl_bram_arbiter

---
 rtl/gl_bram_arbiter_pkg.sv | 18 +
 rtl/gl_bram_arbiter_if.sv | 30 +++
 rtl/gl_bram_arbiter_rr_pick.sv | 28 ++
 rtl/gl_bram_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/gl_bram_arbiter_pkg.sv
// Shared constants and types for the BRAM read arbiter.
package gl_bram_arbiter_pkg;

  localparam int NREQ_DEF      = 3;
  localparam int ADDR_STEP_DEF = 4;
  localparam int NLANES        = 4;

  // Requester slots
  localparam int REQ_DECODE = 0;
  localparam int REQ_MATRIX = 1;
  localparam int REQ_PDIV   = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

endpackage

// File: rtl/gl_bram_arbiter_if.sv
// Requester-side and BRAM-side bus of the arbiter.
interface gl_bram_arbiter_if
  import gl_bram_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
);

  logic [NREQ-1:0]              req;
  logic [NREQ-1:0][31:0]        req_addr;
  logic [NREQ-1:0][1:0]         req_len;
  logic [NREQ-1:0]              gnt;
  logic [31:0]                  bram_addr_out;
  logic [NLANES-1:0][31:0]      bram_read_in;
  logic [NLANES-1:0][31:0]      rd_data;
  logic [NREQ-1:0]              rd_valid;
  logic                         busy;

  // Arbiter side
  modport slave (
    input  req, req_addr, req_len, bram_read_in,
    output gnt, bram_addr_out, rd_data, rd_valid, busy
  );

  // Requesters + BRAM side
  modport master (
    output req, req_addr, req_len, bram_read_in,
    input  gnt, bram_addr_out, rd_data, rd_valid, busy
  );

endinterface

// File: rtl/gl_bram_arbiter_rr_pick.sv
// Combinational round-robin pick: first active request after last_winner.
module gl_rr_pick #(
  parameter int NREQ = 3,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_winner,
  output logic [NREQ-1:0] winner
);

  logic          found;
  logic [IW-1:0] idx;

  // Scan slots last_winner+1 .. last_winner+NREQ (mod NREQ), keep the first hit
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IW'((int'(last_winner) + i) % NREQ);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gl_bram_arbiter.sv
// Round-robin burst arbiter in front of a 4-lane BRAM read port.
// Address issue is a two-state FSM; returned data is tagged through a
// two-deep pipeline so beats still land on the issuing requester after
// a new burst has started.
module gl_bram_arbiter
  import gl_bram_arbiter_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int ADDR_STEP = ADDR_STEP_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  gl_bram_arbiter_if.slave  bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e                  state_q, state_d;
  logic [NREQ-1:0]         gnt_q, gnt_d;
  logic [31:0]             addr_q, addr_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [IW-1:0]           lw_q, lw_d;
  // [0]: tag of beat whose BRAM data is on the lanes now; [1]: rd_valid
  logic [1:0][NREQ-1:0]    tag_pipe_q, tag_pipe_d;
  logic [NLANES-1:0][31:0] rd_q, rd_d;

  logic [NREQ-1:0]         pick_oh;
  logic [IW-1:0]           pick_idx;

  gl_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req         (bus.req),
    .last_winner (lw_q),
    .winner      (pick_oh)
  );

  // One-hot winner to index for the address/length mux
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (pick_oh[i]) pick_idx = IW'(i);
  end

  // Arbitration and address-issue state machine
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    lw_d    = lw_q;
    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (|bus.req) begin
          state_d = ST_BURST;
          gnt_d   = pick_oh;
          addr_d  = bus.req_addr[pick_idx];
          cnt_d   = bus.req_len[pick_idx];
          lw_d    = pick_idx;
        end
      end
      ST_BURST: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end else begin
          addr_d = addr_q + 32'(ADDR_STEP);
          cnt_d  = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Return path: tag follows the address by two cycles; data held when idle
  always_comb begin
    tag_pipe_d[0] = (state_q == ST_BURST) ? gnt_q : '0;
    tag_pipe_d[1] = tag_pipe_q[0];
    rd_d          = (|tag_pipe_q[0]) ? bus.bram_read_in : rd_q;
  end

  // All state; reset discards any beats still in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      lw_q       <= IW'(NREQ - 1);
      tag_pipe_q <= '0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      lw_q       <= lw_d;
      tag_pipe_q <= tag_pipe_d;
      rd_q       <= rd_d;
    end
  end

  assign bus.gnt           = gnt_q;
  assign bus.bram_addr_out = addr_q;
  assign bus.rd_data       = rd_q;
  assign bus.rd_valid      = tag_pipe_q[1];
  assign bus.busy          = (state_q == ST_BURST) | (|tag_pipe_q[0]);

endmodule
